// File: rtl/crypto_ctrl_pkg.sv
// crypto_ctrl_pkg: shared opcodes, error codes, command field positions and sequencer states
package crypto_ctrl_pkg;
   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_RUN  = 3'd2;
   localparam logic [2:0] OP_CLR  = 3'd3;
   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_STRAY    = 3'd1;
   localparam logic [2:0] ERR_OPCODE   = 3'd2;
   localparam logic [2:0] ERR_ARG      = 3'd3;
   localparam logic [2:0] ERR_UNLOADED = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
   localparam int CMD_BIT = 31;
   localparam int OP_HI   = 30;
   localparam int OP_LO   = 28;
   localparam int IDX_HI  = 10;
   localparam int IDX_LO  = 8;
   localparam int CNT_HI  = 4;
   localparam int CNT_LO  = 0;
   typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: loadable up-counter that stops and flags expiry at LIMIT-1
module seq_timeout_counter #(
   parameter int LIMIT = 1024,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);
   logic [W-1:0] count_q, count_d;
   assign expired = count_q == W'(LIMIT - 1);
   always_comb count_d = load ? load_val : (en && !expired) ? count_q + W'(1) : count_q;
   always_ff @(posedge clock)
      if (reset) count_q <= '0;
      else count_q <= count_d;
endmodule

// File: rtl/key_load_sequencer.sv
// key_load_sequencer: decodes host commands, streams key words into the key file, supervises the engine
module key_load_sequencer
   import crypto_ctrl_pkg::*;
#(
   parameter int NUM_KEYS  = 6,
   parameter int KEY_WORDS = 4,
   parameter int SLICE_W   = 5,
   parameter int TIMEOUT   = 1024
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                instr_valid,
   input  logic [31:0]         instr,
   output logic                instr_ready,
   output logic [31:0]         key_data,
   output logic [SLICE_W-1:0]  key_slice,
   output logic [NUM_KEYS-1:0] key_we,
   output logic                eng_start,
   output logic [2:0]          eng_key_sel,
   input  logic                eng_done,
   output logic                busy,
   output logic                error,
   output logic [31:0]         status
);
   state_t                state_q, state_d;
   logic [2:0]            key_q, key_d;
   logic [SLICE_W-1:0]    slice_q, slice_d;
   logic [SLICE_W:0]      rem_q, rem_d;
   logic [NUM_KEYS-1:0]   loaded_q, loaded_d;
   logic [2:0]            last_q, last_d;
   logic                  error_q, error_d;
   logic [2:0]            err_code_q, err_code_d;
   logic [31:0]           key_data_q, key_data_d;
   logic [SLICE_W-1:0]    key_slice_q, key_slice_d;
   logic [NUM_KEYS-1:0]   key_we_q, key_we_d;
   logic                  xfer, idx_ok, cnt_ok, tmo_expired, err_set;
   logic [2:0]            cmd_op, cmd_idx, err_val;
   logic [4:0]            cmd_cnt;
   assign xfer    = instr_valid && instr_ready;
   assign cmd_op  = instr[OP_HI:OP_LO];
   assign cmd_idx = instr[IDX_HI:IDX_LO];
   assign cmd_cnt = instr[CNT_HI:CNT_LO];
   assign idx_ok  = 32'(cmd_idx) < NUM_KEYS;
   assign cnt_ok  = 32'(cmd_cnt) < KEY_WORDS;
   seq_timeout_counter #(.LIMIT(TIMEOUT)) u_tmo (
      .clock    (clock),
      .reset    (reset),
      .load     (state_q == START),
      .load_val ('0),
      .en       (state_q == WAIT),
      .expired  (tmo_expired)
   );
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      slice_d     = slice_q;
      rem_d       = rem_q;
      loaded_d    = loaded_q;
      last_d      = last_q;
      error_d     = error_q;
      err_code_d  = err_code_q;
      key_data_d  = '0;
      key_slice_d = '0;
      key_we_d    = '0;
      err_set     = 1'b0;
      err_val     = ERR_NONE;
      case (state_q)
         IDLE: if (xfer) begin
            if (!instr[CMD_BIT]) begin
               err_set = 1'b1;
               err_val = ERR_STRAY;
            end else case (cmd_op)
               OP_NOP: ;
               OP_LOAD: if (!error_q) begin
                  if (idx_ok && cnt_ok) begin
                     state_d = LOAD;
                     key_d   = cmd_idx;
                     slice_d = '0;
                     rem_d   = (SLICE_W+1)'(cmd_cnt) + (SLICE_W+1)'(1);
                  end else begin
                     err_set = 1'b1;
                     err_val = ERR_ARG;
                  end
               end
               OP_RUN: if (!error_q) begin
                  if (!idx_ok) begin
                     err_set = 1'b1;
                     err_val = ERR_ARG;
                  end else if (!loaded_q[cmd_idx]) begin
                     err_set = 1'b1;
                     err_val = ERR_UNLOADED;
                  end else begin
                     state_d = START;
                     key_d   = cmd_idx;
                  end
               end
               OP_CLR: begin
                  error_d    = 1'b0;
                  err_code_d = ERR_NONE;
               end
               default: begin
                  err_set = 1'b1;
                  err_val = ERR_OPCODE;
               end
            endcase
         end
         // data words are raw here: bit 31 is payload, not a command marker
         LOAD: if (xfer) begin
            key_data_d  = instr;
            key_slice_d = slice_q;
            key_we_d    = NUM_KEYS'(1) << key_q;
            slice_d     = slice_q + SLICE_W'(1);
            rem_d       = rem_q - (SLICE_W+1)'(1);
            if (rem_q == (SLICE_W+1)'(1)) begin
               loaded_d[key_q] = 1'b1;
               state_d         = IDLE;
            end
         end
         START: begin
            last_d  = key_q;
            state_d = WAIT;
         end
         WAIT: if (eng_done) state_d = IDLE;
         else if (tmo_expired) begin
            err_set = 1'b1;
            err_val = ERR_TIMEOUT;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // sticky: the first error code survives until an explicit clear
      if (err_set) begin
         error_d = 1'b1;
         if (!error_q) err_code_d = err_val;
      end
   end
   always_ff @(posedge clock)
      if (reset) begin
         state_q     <= IDLE;
         key_q       <= '0;
         slice_q     <= '0;
         rem_q       <= '0;
         loaded_q    <= '0;
         last_q      <= '0;
         error_q     <= 1'b0;
         err_code_q  <= ERR_NONE;
         key_data_q  <= '0;
         key_slice_q <= '0;
         key_we_q    <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         slice_q     <= slice_d;
         rem_q       <= rem_d;
         loaded_q    <= loaded_d;
         last_q      <= last_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
         key_data_q  <= key_data_d;
         key_slice_q <= key_slice_d;
         key_we_q    <= key_we_d;
      end
   always_comb begin
      status                 = '0;
      status[31]             = busy;
      status[30]             = error_q;
      status[29:27]          = err_code_q;
      status[10:8]           = last_q;
      status[NUM_KEYS-1:0]   = loaded_q;
   end
   assign instr_ready = state_q == IDLE || state_q == LOAD;
   assign eng_start   = state_q == START;
   assign eng_key_sel = (state_q == START || state_q == WAIT) ? key_q : 3'd0;
   assign busy        = state_q != IDLE;
   assign error       = error_q;
   assign key_data    = key_data_q;
   assign key_slice   = key_slice_q;
   assign key_we      = key_we_q;
endmodule
